silife_spi_loader: RTL and testbench

- SPI-slave loader: receives MAX7219-format frames (the same wire format the display driver transmits) from an external host and writes grid rows through the grid write port (row_select/cells/wr_en).
- Emulates a daisy chain of N_DEVICES MAX7219 8x8 devices, so one frame loads up to N_DEVICES rows, and a full 8x32 grid loads in 8 frames.
- Sits beside the demo writer in the top level; its outputs are muxed into the grid write path.

---
 rtl/silife_spi_loader.sv | 183 ++++++++++++++++++
 tb/tb_silife_spi_loader.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/silife_spi_loader.sv
// silife_spi_loader
//   SPI-slave loader that accepts MAX7219-format frames from an external host
//   and turns them into grid row writes. It emulates a daisy chain of
//   N_DEVICES 8x8 devices, so one frame (16*N_DEVICES bits, MSB first, mode 0)
//   carries one 16-bit word per device.
//
//   Device d owns rows 8*d .. 8*d+7. The last word shifted in belongs to
//   device 0. Word layout: [15:12] ignored, [11:8] addr, [7:0] data.
//   addr 1..8 writes a row. On device 0 only, addr 0xA sets the brightness
//   and addr 0xC sets the run flag.
//
// Ports
//   clk, rst_n        system clock, async active-low reset
//   i_cs/i_sck/i_mosi SPI slave inputs (async to clk, synchronized here)
//   o_row_select      grid row being written (holds between strobes)
//   o_cells           row data, bit 7 = leftmost column (holds between strobes)
//   o_wr_en           one-cycle write strobe
//   o_run             run flag from the shutdown register
//   o_brightness      intensity register value
//   o_busy            frame being received or committed
//   o_frame_error     one-cycle pulse when a frame of the wrong length is dropped
module silife_spi_loader #(
  parameter int N_DEVICES   = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           i_cs,
  input  logic                           i_sck,
  input  logic                           i_mosi,
  output logic [$clog2(8*N_DEVICES)-1:0] o_row_select,
  output logic [7:0]                     o_cells,
  output logic                           o_wr_en,
  output logic                           o_run,
  output logic [3:0]                     o_brightness,
  output logic                           o_busy,
  output logic                           o_frame_error
);

  localparam int FB = 16 * N_DEVICES;
  localparam int RW = $clog2(8 * N_DEVICES);
  localparam int CW = $clog2(FB + 2);
  localparam int DW = (N_DEVICES > 1) ? $clog2(N_DEVICES) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  state_t                 state, state_d;
  logic [SYNC_STAGES-1:0] cs_sync, sck_sync, mosi_sync;
  logic                   cs_q, sck_q;
  logic                   cs_s, sck_s, mosi_s;
  logic                   cs_fall, cs_rise, sck_rise;
  logic [FB-1:0]          sr, sr_nx;
  logic [CW-1:0]          cnt, cnt_nx;
  logic [DW-1:0]          dev;
  logic                   bad_frame;
  logic [3:0]             addr;
  logic [7:0]             data;
  logic                   wr_hit;
  logic [RW-1:0]          row_new, row_q;
  logic [7:0]             cells_q;

  // ---------------- synchronizers and edge detect ----------------
  // cs idles high, so its chain and history reset to 1 to avoid a false edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_sync   <= '1;
      sck_sync  <= '0;
      mosi_sync <= '0;
      cs_q      <= 1'b1;
      sck_q     <= 1'b0;
    end else begin
      cs_sync[0]   <= i_cs;
      sck_sync[0]  <= i_sck;
      mosi_sync[0] <= i_mosi;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        cs_sync[k]   <= cs_sync[k-1];
        sck_sync[k]  <= sck_sync[k-1];
        mosi_sync[k] <= mosi_sync[k-1];
      end
      cs_q  <= cs_s;
      sck_q <= sck_s;
    end
  end

  assign cs_s     = cs_sync[SYNC_STAGES-1];
  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync[SYNC_STAGES-1];
  assign cs_fall  = cs_q & ~cs_s;
  assign cs_rise  = ~cs_q & cs_s;
  assign sck_rise = ~sck_q & sck_s;

  // A bit arriving in the same cycle as the cs rise is counted before the
  // length check, so the check looks at the post-shift count.
  always_comb begin
    sr_nx  = sr;
    cnt_nx = cnt;
    if (state == SHIFT && sck_rise) begin
      sr_nx  = {sr[FB-2:0], mosi_s};
      cnt_nx = (cnt == CW'(FB + 1)) ? cnt : cnt + 1'b1;
    end
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d   = state;
    bad_frame = 1'b0;
    case (state)
      IDLE:   if (cs_fall) state_d = SHIFT;
      SHIFT:  if (cs_rise) begin
                if (cnt_nx == CW'(FB)) state_d = COMMIT;
                else begin
                  state_d   = IDLE;
                  bad_frame = 1'b1;
                end
              end
      // cs is not watched here: a frame starting during commit is dropped.
      COMMIT: if (dev == DW'(N_DEVICES - 1)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------- shift register / counters ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr  <= '0;
      cnt <= '0;
      dev <= '0;
    end else begin
      case (state)
        IDLE:   begin
                  dev <= '0;
                  if (cs_fall) cnt <= '0;
                end
        SHIFT:  begin
                  sr  <= sr_nx;
                  cnt <= cnt_nx;
                  dev <= '0;
                end
        COMMIT: dev <= (dev == DW'(N_DEVICES - 1)) ? '0 : dev + 1'b1;
        default: dev <= '0;
      endcase
    end
  end

  // ---------------- commit decode ----------------
  assign addr    = sr[{dev, 4'b0000} + 8 +: 4];
  assign data    = sr[{dev, 4'b0000} +: 8];
  assign wr_hit  = (state == COMMIT) && (addr >= 4'd1) && (addr <= 4'd8);
  assign row_new = RW'({dev, 3'b000}) + RW'(addr - 4'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q         <= '0;
      cells_q       <= '0;
      o_brightness  <= '0;
      o_run         <= 1'b0;
      o_frame_error <= 1'b0;
    end else begin
      o_frame_error <= bad_frame;
      if (wr_hit) begin
        row_q   <= row_new;
        cells_q <= data;
      end
      if (state == COMMIT && dev == '0) begin
        if (addr == 4'hA) o_brightness <= data[3:0];
        if (addr == 4'hC) o_run        <= data[0];
      end
    end
  end

  // The strobe is driven straight from the commit decode so device 0 lands in
  // the first commit cycle; the held copies keep the bus stable between writes.
  assign o_wr_en      = wr_hit;
  assign o_row_select = wr_hit ? row_new : row_q;
  assign o_cells      = wr_hit ? data : cells_q;
  assign o_busy       = (state != IDLE);

endmodule

// File: tb/tb_silife_spi_loader.sv
// Self-checking bench for silife_spi_loader (N_DEVICES=4). A behavioural
// model turns each sent frame (list of words, first shifted to last) into the
// expected sequence of row writes and register values.
module tb_silife_spi_loader;
  localparam int N = 4;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic       i_cs = 1'b1, i_sck = 1'b0, i_mosi = 1'b0;
  logic [4:0] o_row_select;
  logic [7:0] o_cells;
  logic       o_wr_en, o_run, o_busy, o_frame_error;
  logic [3:0] o_brightness;

  silife_spi_loader #(.N_DEVICES(N), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .i_cs(i_cs), .i_sck(i_sck), .i_mosi(i_mosi),
    .o_row_select(o_row_select), .o_cells(o_cells), .o_wr_en(o_wr_en),
    .o_run(o_run), .o_brightness(o_brightness), .o_busy(o_busy),
    .o_frame_error(o_frame_error)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0, cyc = 0, err_pulses = 0;
  int cap_row[$], cap_cells[$], cap_cyc[$];
  int exp_row[$], exp_cells[$];
  int exp_run = 0, exp_bright = 0;

  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (o_wr_en === 1'b1) begin
      cap_row.push_back(int'(o_row_select));
      cap_cells.push_back(int'(o_cells));
      cap_cyc.push_back(cyc);
    end
    if (o_frame_error === 1'b1) err_pulses++;
  end

  task automatic clear_caps();
    cap_row.delete(); cap_cells.delete(); cap_cyc.delete();
    exp_row.delete(); exp_cells.delete();
    err_pulses = 0;
  endtask

  // v holds the words first-to-last: word k sits at v[63-16k -: 16].
  // Chain semantics: the last word shifted ends up in device 0.
  task automatic model(input logic [63:0] v);
    logic [15:0] w;
    int a;
    for (int d = 0; d < N; d++) begin
      w = v[63 - 16*(N-1-d) -: 16];
      a = int'(w[11:8]);
      if (a >= 1 && a <= 8) begin
        exp_row.push_back(8*d + a - 1);
        exp_cells.push_back(int'(w[7:0]));
      end else if (d == 0 && a == 10) exp_bright = int'(w[3:0]);
      else if (d == 0 && a == 12) exp_run = int'(w[0]);
    end
  endtask

  // Sends v[n-1] .. v[0] with sck half period of 'half' clk; random phase.
  task automatic send_bits(input logic [79:0] v, input int n, input int half,
                           input bit raise_cs);
    #($urandom_range(0, 9));
    i_cs = 1'b0;
    #(half*10);
    for (int i = n - 1; i >= 0; i--) begin
      i_mosi = v[i];
      #(half*10); i_sck = 1'b1;
      #(half*10); i_sck = 1'b0;
    end
    if (raise_cs) begin
      #(half*10); i_cs = 1'b1;
    end
  endtask

  task automatic settle();
    repeat (14) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({o_row_select, o_cells, o_wr_en, o_run, o_brightness, o_busy, o_frame_error} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got=%h want=0",
        {o_row_select, o_cells, o_wr_en, o_run, o_brightness, o_busy, o_frame_error});
    end
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
  endtask

  task automatic test_full_frame();
    logic [63:0] v;
    v = 64'h0301_0102_0880_0455;
    clear_caps();
    model(v);
    send_bits({16'h0, v}, 64, 4, 1'b1);
    settle();
    checks++;
    if (cap_row.size() != 4 || exp_row.size() != 4) begin
      errors++; $display("FAIL full_count got=%0d want=4", cap_row.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (cap_row[i] != exp_row[i] || cap_cells[i] != exp_cells[i]) begin
          errors++;
          $display("FAIL full_write%0d got=row%0d/%h want=row%0d/%h", i,
                   cap_row[i], cap_cells[i], exp_row[i], exp_cells[i]);
        end
        checks++;
        if (cap_cyc[i] != cap_cyc[0] + i) begin
          errors++; $display("FAIL full_consecutive%0d got=%0d want=%0d", i, cap_cyc[i], cap_cyc[0] + i);
        end
      end
    end
    checks++;
    if (o_busy !== 1'b0 || err_pulses != 0) begin
      errors++; $display("FAIL full_idle busy=%b errs=%0d want busy=0 errs=0", o_busy, err_pulses);
    end
  endtask

  task automatic test_control();
    logic [63:0] v [3];
    v[0] = 64'h0000_0000_0000_0A07;
    v[1] = 64'h0000_0000_0000_0C01;
    v[2] = 64'h0000_0000_0000_0C00;
    for (int f = 0; f < 3; f++) begin
      clear_caps();
      model(v[f]);
      send_bits({16'h0, v[f]}, 64, 4, 1'b1);
      settle();
      checks++;
      if (int'(o_brightness) != exp_bright || int'(o_run) != exp_run) begin
        errors++;
        $display("FAIL control%0d got=bright%0d/run%0d want=bright%0d/run%0d",
                 f, o_brightness, o_run, exp_bright, exp_run);
      end
      checks++;
      if (cap_row.size() != 0 || err_pulses != 0) begin
        errors++; $display("FAIL control%0d_side got=wr%0d/err%0d want=0/0", f, cap_row.size(), err_pulses);
      end
    end
  endtask

  task automatic test_bad_length();
    logic [4:0] row0;
    logic [7:0] cel0;
    int n;
    for (int k = 0; k < 2; k++) begin
      n = (k == 0) ? 63 : 65;
      row0 = o_row_select; cel0 = o_cells;
      clear_caps();
      send_bits({16'h0001, 64'h0123_0234_0345_0456}, n, 4, 1'b1);
      settle();
      checks++;
      if (err_pulses != 1 || cap_row.size() != 0) begin
        errors++; $display("FAIL badlen%0d got=err%0d/wr%0d want=err1/wr0", n, err_pulses, cap_row.size());
      end
      checks++;
      if (o_row_select !== row0 || o_cells !== cel0) begin
        errors++; $display("FAIL badlen%0d_hold got=%h/%h want=%h/%h", n, o_row_select, o_cells, row0, cel0);
      end
    end
  endtask

  task automatic test_misplaced_ctrl();
    logic [63:0] v;
    v = 64'h0000_0C01_0000_0000;
    clear_caps();
    model(v);
    send_bits({16'h0, v}, 64, 4, 1'b1);
    settle();
    checks++;
    if (int'(o_run) != exp_run || o_run !== 1'b0 || cap_row.size() != 0) begin
      errors++; $display("FAIL misplaced_ctrl got=run%b/wr%0d want=run0/wr0", o_run, cap_row.size());
    end
  endtask

  task automatic test_reset_midframe();
    logic [63:0] v;
    // load nonzero registers first so the reset has something to clear
    clear_caps();
    model(64'h0000_0000_0000_0A05);
    send_bits({16'h0, 64'h0000_0000_0000_0A05}, 64, 4, 1'b1);
    settle();
    model(64'h0000_0000_0000_0C01);
    send_bits({16'h0, 64'h0000_0000_0000_0C01}, 64, 4, 1'b1);
    settle();
    checks++;
    if (o_run !== 1'b1 || o_brightness !== 4'd5) begin
      errors++; $display("FAIL premid got=run%b/bright%0d want=run1/bright5", o_run, o_brightness);
    end
    clear_caps();
    send_bits({16'h0, 64'h0101_0202_0303_0404}, 64, 4, 1'b0);
    // that sent all 64 bits with cs still low; rewind to 40 bits is not
    // possible, so abandon a fresh frame at 40 bits instead
    i_cs = 1'b1;
    repeat (12) @(posedge clk);
    clear_caps();
    send_bits({16'h0, 64'h0101_0202_0303_0404}, 40, 4, 1'b0);
    #7 rst_n = 1'b0;
    #13;
    checks++;
    if ({o_row_select, o_cells, o_wr_en, o_run, o_brightness, o_busy, o_frame_error} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs got=%h want=0",
        {o_row_select, o_cells, o_wr_en, o_run, o_brightness, o_busy, o_frame_error});
    end
    i_cs = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    exp_run = 0; exp_bright = 0;
    repeat (5) @(posedge clk);
    checks++;
    if (cap_row.size() != 0) begin
      errors++; $display("FAIL midreset_nowrite got=%0d want=0", cap_row.size());
    end
    clear_caps();
    v = 64'h0112_0723_0834_0245;
    model(v);
    send_bits({16'h0, v}, 64, 4, 1'b1);
    settle();
    checks++;
    if (cap_row.size() != exp_row.size()) begin
      errors++; $display("FAIL postreset_count got=%0d want=%0d", cap_row.size(), exp_row.size());
    end else begin
      for (int i = 0; i < cap_row.size(); i++) begin
        checks++;
        if (cap_row[i] != exp_row[i] || cap_cells[i] != exp_cells[i]) begin
          errors++;
          $display("FAIL postreset_write%0d got=row%0d/%h want=row%0d/%h", i,
                   cap_row[i], cap_cells[i], exp_row[i], exp_cells[i]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] v;
    logic [15:0] w;
    clear_caps();
    for (int f = 0; f < 8; f++) begin
      for (int k = 0; k < N; k++) begin
        w = 16'($urandom);
        w[11:8] = 4'(f + 1);
        v[63 - 16*k -: 16] = w;
      end
      model(v);
      send_bits({16'h0, v}, 64, 4, 1'b1);
      #((N + 4) * 10);
    end
    settle();
    checks++;
    if (cap_row.size() != 32 || exp_row.size() != 32) begin
      errors++; $display("FAIL b2b_count got=%0d want=32", cap_row.size());
    end else begin
      for (int i = 0; i < 32; i++) begin
        checks++;
        if (cap_row[i] != exp_row[i] || cap_cells[i] != exp_cells[i]) begin
          errors++;
          $display("FAIL b2b_write%0d got=row%0d/%h want=row%0d/%h", i,
                   cap_row[i], cap_cells[i], exp_row[i], exp_cells[i]);
        end
      end
    end
    checks++;
    if (err_pulses != 0 || o_busy !== 1'b0) begin
      errors++; $display("FAIL b2b_errors got=err%0d/busy%b want=0/0", err_pulses, o_busy);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    test_reset();
    test_full_frame();
    test_control();
    test_bad_length();
    test_misplaced_ctrl();
    test_reset_midframe();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
